deposit_ctrl: RTL and testbench
===============================

Name: deposit_ctrl

Overview:
Shares override access to one WIDTH-bit state register between N_REQ requesters (testbench agents, debug port, scan loader). It provides reg-style DEPOSIT (one-shot overwrite, later functional writes win), sticky FORCE (output pinned until RELEASE) and RELEASE. The block sits beside the functional write path, with round-robin arbitration and a single-owner force lock.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, width of the controlled register

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
func_we  input  1  functional write enable
func_d  input  WIDTH  functional write data
req_valid  input  N_REQ  per-requester request; held until ack
req_op  input  2*N_REQ  per-requester opcode: 00 DEPOSIT, 01 FORCE, 10 RELEASE, 11 reserved
req_data  input  WIDTH*N_REQ  per-requester value; used by DEPOSIT and FORCE
ack  output  N_REQ  one-hot, single-cycle completion pulse
q  output  WIDTH  visible register value
forced  output  1  force lock held
owner  output  $clog2(N_REQ)  index of the force owner; valid only while forced
collide  output  1  pulse: a functional write was dropped because a DEPOSIT won
op_err  output  1  pulse: a reserved opcode was acknowledged

Behaviour:
- Reset (clk edge with rst=1): shadow register=0, q=0, forced=0, owner=0, ack=0, collide=0, op_err=0, round-robin pointer=0. Reset overrides every in-flight request, and a held force is dropped.
- State: IDLE (no lock) and FORCED (lock held by owner).
- Eligibility: requester i is eligible when req_valid[i]=1 and ack[i]=0 in the current cycle. This masks a double grant while the requester drops valid.
- In FORCED, only the owner is eligible. Other requesters stall with no ack.
- Arbitration: round-robin starting at the pointer. At most one grant per cycle. After a grant the pointer moves to the granted index+1, wrapping modulo N_REQ.
- Latency: a request granted in cycle t has ack[i]=1 in cycle t+1. Its effect on q, forced and owner is also visible in t+1.
- DEPOSIT in IDLE: shadow <= req_data. If func_we=1 in the same cycle, the deposit wins and collide=1 in t+1.
- DEPOSIT by the owner in FORCED: shadow <= req_data, but q is unchanged. The value is lost at RELEASE (see below).
- Functional write without a deposit grant: shadow <= func_d. This applies in both states.
- FORCE in IDLE: force_val <= req_data, state -> FORCED, owner <= i.
- FORCE by the owner in FORCED: force_val <= req_data, and the owner keeps the lock.
- RELEASE by the owner: shadow <= force_val and state -> IDLE, giving reg semantics (the forced value persists until the next write). If func_we=1 in the release cycle, func_d wins over force_val.
- RELEASE in IDLE: acked, no effect.
- Opcode 11: acked, no state change, op_err=1 in t+1.
- q = force_val in FORCED, otherwise shadow. q is registered, not combinational from inputs.
- Dropping req_valid before ack withdraws the request with no effect.

Decomposition:
- Package deposit_ctrl_pkg: op_e enum (OP_DEPOSIT, OP_FORCE, OP_RELEASE, OP_RSVD), state_e (ST_IDLE, ST_FORCED), and an rr_next helper function.
- Sub-module rr_arbiter: N-wide round-robin arbiter with eligibility mask in, one-hot grant out, and pointer update on grant. It is reusable across the codebase.

Test Plan:
- Reset then idle: after rst, q=0, forced=0, no ack. func_we=1, func_d=8'h5A -> q=8'h5A next cycle.
- Deposit vs functional write: req0 DEPOSIT 8'h11 with func_we=1, func_d=8'h22 in the same cycle -> q=8'h11, collide=1. The next func write 8'h33 -> q=8'h33.
- Force lock: req1 FORCE 8'hF0 -> forced=1, owner=1, q=8'hF0. func writes 8'h01 and 8'h02 leave q=8'hF0. req2 DEPOSIT stalls with no ack.
- Release: req1 RELEASE -> forced=0 and q=8'hF0 holds. The stalled req2 DEPOSIT 8'h77 is then acked and q=8'h77. Repeat with func_we=1, func_d=8'hAB in the release cycle -> q=8'hAB.
- Round-robin fairness: all 4 requesters issue DEPOSIT continuously from pointer 0 -> acks in order 0,1,2,3,0. No requester is acked on back-to-back cycles.
- Reserved op and reset mid-force: req3 op 11 -> ack[3], op_err=1, q unchanged. Then req0 FORCE 8'hC3 followed by rst -> q=0, forced=0.

Source files
------------

// File: rtl/deposit_ctrl_pkg.sv
// Shared types and helpers for the deposit/force override controller.
package deposit_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_DEPOSIT = 2'b00,
        OP_FORCE   = 2'b01,
        OP_RELEASE = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_FORCED = 1'b1
    } state_e;

    // Next round-robin start index after a grant to idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/deposit_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from an eligibility mask, searching
// upward from a pointer that moves past the winner after every grant.
module rr_arbiter
    import deposit_ctrl_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  elig,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] ptr;
    logic [IW:0]   cand;

    // First eligible index at or after the pointer, modulo N.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_valid && elig[cand[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer advances to the slot just past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= IW'(rr_next(32'(grant_idx), N));
        end
    end

endmodule

// File: rtl/deposit_ctrl.sv
// Override controller for one register: arbitrated DEPOSIT / FORCE / RELEASE
// requests alongside the functional write path, with a single-owner force lock.
module deposit_ctrl
    import deposit_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       func_we,
    input  logic [WIDTH-1:0]           func_d,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [2*N_REQ-1:0]         req_op,
    input  logic [WIDTH*N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]           ack,
    output logic [WIDTH-1:0]           q,
    output logic                       forced,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       collide,
    output logic                       op_err
);

    localparam int unsigned OW = $clog2(N_REQ);

    state_e           state, state_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic [WIDTH-1:0] force_val, fval_n;
    logic [WIDTH-1:0] q_n;
    logic [OW-1:0]    owner_n;
    logic [N_REQ-1:0] ack_n;
    logic             collide_n;
    logic             op_err_n;
    logic             dep_win;

    op_e              op_arr   [N_REQ];
    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic [OW-1:0]    gidx;
    logic             gvalid;

    // A requester already acked this cycle is masked so it cannot be granted
    // twice while dropping valid; under a lock only the owner may compete.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_arr[i]   = op_e'(req_op[2*i +: 2]);
        assign data_arr[i] = req_data[WIDTH*i +: WIDTH];
        assign elig[i]     = req_valid[i] & ~ack[i] &
                             ((state == ST_IDLE) | (owner == OW'(i)));
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .elig        (elig),
        .grant       (grant),
        .grant_idx   (gidx),
        .grant_valid (gvalid)
    );

    // Apply the granted operation, then the functional write unless a deposit won.
    always_comb begin
        state_n   = state;
        shadow_n  = shadow;
        fval_n    = force_val;
        owner_n   = owner;
        ack_n     = '0;
        collide_n = 1'b0;
        op_err_n  = 1'b0;
        dep_win   = 1'b0;
        if (gvalid) begin
            ack_n = grant;
            case (op_arr[gidx])
                OP_DEPOSIT: begin
                    shadow_n  = data_arr[gidx];
                    dep_win   = 1'b1;
                    collide_n = func_we;
                end
                OP_FORCE: begin
                    fval_n  = data_arr[gidx];
                    state_n = ST_FORCED;
                    owner_n = gidx;
                end
                OP_RELEASE: begin
                    if (state == ST_FORCED) begin
                        shadow_n = force_val;
                        state_n  = ST_IDLE;
                    end
                end
                OP_RSVD: begin
                    op_err_n = 1'b1;
                end
            endcase
        end
        // Ordered after RELEASE so a same-cycle functional write beats force_val.
        if (func_we && !dep_win) begin
            shadow_n = func_d;
        end
        q_n = (state_n == ST_FORCED) ? fval_n : shadow_n;
    end

    // State, data and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            force_val <= '0;
            owner     <= '0;
            ack       <= '0;
            q         <= '0;
            collide   <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            force_val <= fval_n;
            owner     <= owner_n;
            ack       <= ack_n;
            q         <= q_n;
            collide   <= collide_n;
            op_err    <= op_err_n;
        end
    end

    assign forced = (state == ST_FORCED);

endmodule

// File: tb/tb_deposit_ctrl.sv
// Vector-table bench for deposit_ctrl with an expected-result queue.
module tb_deposit_ctrl;

    localparam logic [1:0] D = 2'b00;
    localparam logic [1:0] F = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        func_we = 1'b0;
    logic [7:0]  func_d = '0;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        forced;
    logic [1:0]  owner;
    logic        collide;
    logic        op_err;

    deposit_ctrl #(.N_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .func_we   (func_we),
        .func_d    (func_d),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .ack       (ack),
        .q         (q),
        .forced    (forced),
        .owner     (owner),
        .collide   (collide),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        fwe;
        logic [7:0]  fd;
        logic [3:0]  valid;
        logic [7:0]  op;
        logic [31:0] data;
        logic [3:0]  eack;
        logic [7:0]  eq;
        logic        ef;
        logic [1:0]  eown;
        logic        ecol;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic [3:0] prev_ack = '0;

    function automatic logic [7:0] ops(input logic [1:0] o3, input logic [1:0] o2,
                                       input logic [1:0] o1, input logic [1:0] o0);
        return {o3, o2, o1, o0};
    endfunction

    task automatic add(input string name, input logic r, input logic fwe,
                       input logic [7:0] fd, input logic [3:0] valid,
                       input logic [7:0] op, input logic [31:0] data,
                       input logic [3:0] eack, input logic [7:0] eq, input logic ef,
                       input logic [1:0] eown, input logic ecol, input logic eerr);
        vec_t v;
        v.name = name; v.rst = r; v.fwe = fwe; v.fd = fd; v.valid = valid;
        v.op = op; v.data = data; v.eack = eack; v.eq = eq; v.ef = ef;
        v.eown = eown; v.ecol = ecol; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic check_one();
        vec_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        total++;
        if (ack !== e.eack || q !== e.eq || forced !== e.ef ||
            (e.ef && owner !== e.eown) || collide !== e.ecol || op_err !== e.eerr) begin
            bad++;
            $display("FAIL %s: got ack=%b q=%h forced=%b owner=%0d collide=%b op_err=%b; want ack=%b q=%h forced=%b owner=%0d collide=%b op_err=%b",
                     e.name, ack, q, forced, owner, collide, op_err,
                     e.eack, e.eq, e.ef, e.eown, e.ecol, e.eerr);
        end
        total++;
        if ((ack & prev_ack) != 4'b0000) begin
            bad++;
            $display("FAIL back_to_back_ack at %s: ack=%b prev=%b, want no overlap",
                     e.name, ack, prev_ack);
        end
        prev_ack = ack;
    endtask

    initial begin
        //   name                 rst fwe fd     valid    op              data           eack     eq     f  own col err
        add("reset_inflight",     1, 0, 8'h00, 4'b0001, ops(D,D,D,D), 32'h00000099, 4'b0000, 8'h00, 0, 0, 0, 0);
        add("idle",               0, 0, 8'h00, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'h00, 0, 0, 0, 0);
        add("func_write",         0, 1, 8'h5A, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'h5A, 0, 0, 0, 0);
        add("deposit_vs_func",    0, 1, 8'h22, 4'b0001, ops(D,D,D,D), 32'h00000011, 4'b0001, 8'h11, 0, 0, 1, 0);
        add("func_after_dep",     0, 1, 8'h33, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'h33, 0, 0, 0, 0);
        add("force_req1",         0, 0, 8'h00, 4'b0010, ops(D,D,F,D), 32'h0000F000, 4'b0010, 8'hF0, 1, 1, 0, 0);
        add("func_in_force",      0, 1, 8'h01, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'hF0, 1, 1, 0, 0);
        add("stall_req2",         0, 1, 8'h02, 4'b0100, ops(D,D,D,D), 32'h00770000, 4'b0000, 8'hF0, 1, 1, 0, 0);
        add("release_req1",       0, 0, 8'h00, 4'b0110, ops(D,D,R,D), 32'h00770000, 4'b0010, 8'hF0, 0, 0, 0, 0);
        add("stalled_dep_req2",   0, 0, 8'h00, 4'b0100, ops(D,D,D,D), 32'h00770000, 4'b0100, 8'h77, 0, 0, 0, 0);
        add("force_req1_again",   0, 0, 8'h00, 4'b0010, ops(D,D,F,D), 32'h00005C00, 4'b0010, 8'h5C, 1, 1, 0, 0);
        add("hold_force",         0, 0, 8'h00, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'h5C, 1, 1, 0, 0);
        add("release_with_func",  0, 1, 8'hAB, 4'b0010, ops(D,D,R,D), 32'h0,        4'b0010, 8'hAB, 0, 0, 0, 0);
        add("after_release",      0, 0, 8'h00, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'hAB, 0, 0, 0, 0);
        add("reset_rr",           1, 0, 8'h00, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'h00, 0, 0, 0, 0);

        // All four requesters hold DEPOSIT: grants rotate 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            add("rr_fair", 0, 0, 8'h00, 4'b1111, ops(D,D,D,D), 32'hA3A2A1A0,
                4'(1 << (k % 4)), 8'hA0 + 8'(k % 4), 0, 0, 0, 0);
        end

        add("rr_drop",            0, 0, 8'h00, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'hA3, 0, 0, 0, 0);
        add("rsvd_op",            0, 0, 8'h00, 4'b1000, ops(X,D,D,D), 32'hEE000000, 4'b1000, 8'hA3, 0, 0, 0, 1);
        add("after_rsvd",         0, 0, 8'h00, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'hA3, 0, 0, 0, 0);
        add("force_req0",         0, 0, 8'h00, 4'b0001, ops(D,D,D,F), 32'h000000C3, 4'b0001, 8'hC3, 1, 0, 0, 0);
        add("reset_mid_force",    1, 0, 8'h00, 4'b0001, ops(D,D,D,F), 32'h000000C3, 4'b0000, 8'h00, 0, 0, 0, 0);
        add("idle_after_reset",   0, 0, 8'h00, 4'b0000, ops(D,D,D,D), 32'h0,        4'b0000, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check_one();
            rst       = vecs[i].rst;
            func_we   = vecs[i].fwe;
            func_d    = vecs[i].fd;
            req_valid = vecs[i].valid;
            req_op    = vecs[i].op;
            req_data  = vecs[i].data;
            sb.push_back(vecs[i]);
        end
        @(negedge clk);
        check_one();
        rst       = 1'b0;
        func_we   = 1'b0;
        req_valid = '0;

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
